// File: rtl/mem_a_stream_reader_if.sv
// Port-B RAM bus plus the outgoing valid/ready data stream.
// master = reader side, slave = RAM model / downstream consumer.
interface mem_a_stream_reader_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 256
);
   logic [ADDR_W-1:0]   address2;
   logic                chipselect2;
   logic                write2;
   logic                clken2;
   logic [DATA_W/8-1:0] byteenable2;
   logic [DATA_W-1:0]   writedata2;
   logic [DATA_W-1:0]   readdata2;
   logic                m_valid;
   logic                m_ready;
   logic [DATA_W-1:0]   m_data;
   logic                m_last;

   modport master (
      output address2, chipselect2, write2, clken2,
      output byteenable2, writedata2,
      input  readdata2,
      output m_valid, m_data, m_last,
      input  m_ready
   );

   modport slave (
      input  address2, chipselect2, write2, clken2,
      input  byteenable2, writedata2,
      output readdata2,
      input  m_valid, m_data, m_last,
      output m_ready
   );
endinterface

// File: rtl/mem_a_stream_reader.sv
// Strided read sequencer for FPGA_Mem_A port B feeding a
// credit-managed output FIFO with a last-beat flag.
module mem_a_stream_reader #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 256,
   parameter int LEN_W      = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [ADDR_W-1:0] stride,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   mem_a_stream_reader_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] stride_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued_q;
   logic              inflight_q;
   logic              inflight_last_q;
   logic              done_q;

   logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;

   logic credit;
   logic issue;
   logic last_issue;
   logic push;
   logic pop;
   logic head_last;
   logic final_pop;
   logic accept;
   logic zero_len;

   // Credit uses the registered count only; a same-cycle pop
   // does not free a slot until the next cycle.
   always_comb begin
      credit     = (count + CW'(inflight_q)) < DEPTH_C;
      issue      = (state == ISSUE) && credit && !abort;
      last_issue = issued_q == (len_q - LEN_W'(1));
      push       = inflight_q;
      pop        = bus.m_valid && bus.m_ready;
      head_last  = fifo_last[rd_ptr];
      final_pop  = pop && head_last;
      accept     = (state == IDLE) && start && !abort;
      zero_len   = length == '0;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept && !zero_len)
               state_nx = ISSUE;
         end
         ISSUE: begin
            if (issue && last_issue)
               state_nx = DRAIN;
         end
         DRAIN: begin
            if (final_pop)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (abort)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         addr_q          <= '0;
         stride_q        <= '0;
         len_q           <= '0;
         issued_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         fifo_last       <= '0;
      end else begin
         state  <= state_nx;
         done_q <= !abort &&
                   ((accept && zero_len) ||
                    (state == DRAIN && final_pop));
         if (accept) begin
            addr_q   <= base_addr;
            stride_q <= stride;
            len_q    <= length;
            issued_q <= '0;
         end else if (issue) begin
            addr_q   <= addr_q + stride_q;
            issued_q <= issued_q + LEN_W'(1);
         end
         // Abort flushes the FIFO and drops any read still returning.
         if (abort) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
         end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && last_issue;
            if (push) begin
               wr_ptr            <= wr_ptr + PW'(1);
               fifo_last[wr_ptr] <= inflight_last_q;
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !abort)
         fifo_data[wr_ptr] <= bus.readdata2;
   end

   assign busy            = state != IDLE;
   assign done            = done_q;
   assign bus.address2    = addr_q;
   assign bus.chipselect2 = issue;
   assign bus.write2      = 1'b0;
   assign bus.clken2      = 1'b1;
   assign bus.byteenable2 = '1;
   assign bus.writedata2  = '0;
   assign bus.m_valid     = count != '0;
   assign bus.m_data      = fifo_data[rd_ptr];
   assign bus.m_last      = bus.m_valid && head_last;
endmodule
